// File: rtl/bp_common_pkg.sv
// Shared types for the BlackParrot nonsynthesizable monitors.
//   bp_if_mon_err_e   : ready/valid monitor error codes
//   bp_if_mon_state_e : per-channel ready/valid monitor FSM states
//   bsg_safe_clog2    : clog2 that never returns 0, for width computations
package bp_common_pkg;

    typedef enum logic [1:0] {
        e_if_none        = 2'd0,
        e_if_valid_drop  = 2'd1,
        e_if_data_change = 2'd2,
        e_if_timeout     = 2'd3
    } bp_if_mon_err_e;

    typedef enum logic [1:0] {
        e_idle  = 2'd0,
        e_stall = 2'd1,
        e_err   = 2'd2
    } bp_if_mon_state_e;

    // clog2 with a floor of 1 so a single-entry index is still one bit wide
    function automatic int unsigned bsg_safe_clog2(input int unsigned x);
        return (x <= 32'd1) ? 32'd1 : 32'($clog2(x));
    endfunction

endpackage

// File: rtl/bp_nonsynth_if_monitor_chan.sv
// Per-channel ready/valid protocol checker.
// Tracks one channel through idle / stalled / errored, holding the payload
// captured at the start of a stall and counting completed handshakes.
//   i_clk, i_rst      : clock, async active-high reset
//   i_en              : checking enable; low freezes all state
//   i_v, i_ready      : channel handshake
//   i_data            : channel payload
//   o_err_v_c         : combinational; this cycle's sample is a violation
//   o_err_code_c      : combinational; code of that violation
//   o_chan_err        : channel has errored (sticky until reset)
//   o_count           : saturating handshake count
module bp_nonsynth_if_monitor_chan
    import bp_common_pkg::*;
#(
    parameter int unsigned data_width_p     = 64,
    parameter int unsigned timeout_cycles_p = 1024,
    parameter int unsigned count_width_p    = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_en,
    input  logic                     i_v,
    input  logic                     i_ready,
    input  logic [data_width_p-1:0]  i_data,
    output logic                     o_err_v_c,
    output bp_if_mon_err_e           o_err_code_c,
    output logic                     o_chan_err,
    output logic [count_width_p-1:0] o_count
);

    localparam int unsigned STALL_W = bsg_safe_clog2(timeout_cycles_p + 32'd1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(timeout_cycles_p - 32'd1);

    bp_if_mon_state_e         r_state;
    logic [data_width_p-1:0]  r_hold;
    logic [STALL_W-1:0]       r_stall_cnt;
    logic [count_width_p-1:0] r_count;
    bp_if_mon_err_e           w_err_code;

    // Violation decode for a stalled channel; valid_drop masks the payload
    // compare, and a payload change outranks the timeout.
    always_comb begin
        w_err_code = e_if_none;
        if (i_en && (r_state == e_stall)) begin
            if (!i_v) begin
                w_err_code = e_if_valid_drop;
            end else if (i_data != r_hold) begin
                w_err_code = e_if_data_change;
            end else if (!i_ready && (r_stall_cnt == STALL_LAST)) begin
                w_err_code = e_if_timeout;
            end
        end
    end

    assign o_err_v_c    = (w_err_code != e_if_none);
    assign o_err_code_c = w_err_code;
    assign o_chan_err   = (r_state == e_err);
    assign o_count      = r_count;

    // Channel FSM, hold register, stall counter and handshake counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= e_idle;
            r_hold      <= '0;
            r_stall_cnt <= '0;
            r_count     <= '0;
        end else if (i_en) begin
            case (r_state)
                e_idle: begin
                    if (i_v && i_ready) begin
                        if (r_count != '1) begin
                            r_count <= r_count + count_width_p'(1);
                        end
                    end else if (i_v) begin
                        r_hold      <= i_data;
                        r_stall_cnt <= STALL_W'(1);
                        r_state     <= e_stall;
                    end
                end
                e_stall: begin
                    if (o_err_v_c) begin
                        r_state <= e_err;
                    end else if (i_ready) begin
                        if (r_count != '1) begin
                            r_count <= r_count + count_width_p'(1);
                        end
                        r_stall_cnt <= '0;
                        r_state     <= e_idle;
                    end else begin
                        r_stall_cnt <= r_stall_cnt + STALL_W'(1);
                    end
                end
                e_err: begin
                    r_state <= e_err;
                end
                default: begin
                    r_state <= e_idle;
                end
            endcase
        end
    end

endmodule

// File: rtl/bp_nonsynth_if_monitor.sv
// Runtime ready/valid protocol monitor for the test harness.
// One checker per channel plus a first-error latch (lowest channel index wins
// on a tie) and per-error reporting.
//   clk_i, reset_i  : clock, async active-high reset
//   en_i            : checking enable
//   v_i, ready_i    : per-channel handshake
//   data_i          : per-channel payloads, channel k at [k*data_width_p +: data_width_p]
//   error_o         : sticky, any error latched
//   error_chan_o    : channel of the first latched error
//   error_code_o    : code of the first latched error
//   chan_error_o    : sticky per-channel error flags
//   count_o         : per-channel saturating handshake counts
// report_en_p = 0 silences the per-error messages for benches that provoke
// errors on purpose; the outputs behave identically either way.
module bp_nonsynth_if_monitor
    import bp_common_pkg::*;
#(
    parameter int unsigned num_channels_p   = 4,
    parameter int unsigned data_width_p     = 64,
    parameter int unsigned timeout_cycles_p = 1024,
    parameter int unsigned count_width_p    = 32,
    parameter int unsigned fatal_on_error_p = 0,
    parameter int unsigned report_en_p      = 1
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic                                     en_i,
    input  logic [num_channels_p-1:0]                v_i,
    input  logic [num_channels_p-1:0]                ready_i,
    input  logic [num_channels_p*data_width_p-1:0]   data_i,
    output logic                                     error_o,
    output logic [bsg_safe_clog2(num_channels_p)-1:0] error_chan_o,
    output logic [1:0]                               error_code_o,
    output logic [num_channels_p-1:0]                chan_error_o,
    output logic [num_channels_p*count_width_p-1:0]  count_o
);

    localparam int unsigned CHAN_W = bsg_safe_clog2(num_channels_p);

    logic [num_channels_p-1:0] w_err_v;
    logic [1:0]                w_err_code [num_channels_p];
    logic                      w_found;
    logic [CHAN_W-1:0]         w_first_chan;
    logic [1:0]                w_first_code;

    logic                      r_error;
    logic [CHAN_W-1:0]         r_error_chan;
    logic [1:0]                r_error_code;
    logic [63:0]               r_cycle;

    for (genvar k = 0; k < num_channels_p; k++) begin : g_chan
        bp_nonsynth_if_monitor_chan #(
            .data_width_p     (data_width_p),
            .timeout_cycles_p (timeout_cycles_p),
            .count_width_p    (count_width_p)
        ) u_chan (
            .i_clk        (clk_i),
            .i_rst        (reset_i),
            .i_en         (en_i),
            .i_v          (v_i[k]),
            .i_ready      (ready_i[k]),
            .i_data       (data_i[k*data_width_p +: data_width_p]),
            .o_err_v_c    (w_err_v[k]),
            .o_err_code_c (w_err_code[k]),
            .o_chan_err   (chan_error_o[k]),
            .o_count      (count_o[k*count_width_p +: count_width_p])
        );
    end

    // Lowest-index erring channel this cycle
    always_comb begin
        w_found      = 1'b0;
        w_first_chan = '0;
        w_first_code = 2'(e_if_none);
        for (int unsigned k = 0; k < num_channels_p; k++) begin
            if (w_err_v[k] && !w_found) begin
                w_found      = 1'b1;
                w_first_chan = CHAN_W'(k);
                w_first_code = w_err_code[k];
            end
        end
    end

    // First-error latch; later errors only show up on chan_error_o
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_error      <= 1'b0;
            r_error_chan <= '0;
            r_error_code <= 2'(e_if_none);
            r_cycle      <= '0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
            if (w_found && !r_error) begin
                r_error      <= 1'b1;
                r_error_chan <= w_first_chan;
                r_error_code <= w_first_code;
            end
        end
    end

    assign error_o      = r_error;
    assign error_chan_o = r_error_chan;
    assign error_code_o = r_error_code;

    // One message per erring channel in the cycle the violation is sampled
    always_ff @(posedge clk_i) begin
        if ((report_en_p != 0) && !reset_i) begin
            for (int unsigned k = 0; k < num_channels_p; k++) begin
                if (w_err_v[k]) begin
                    if (fatal_on_error_p != 0) begin
                        $fatal(1, "if_monitor: chan %0d code %0d cycle %0d data %h",
                               k, w_err_code[k], r_cycle,
                               data_i[k*data_width_p +: data_width_p]);
                    end else begin
                        $error("if_monitor: chan %0d code %0d cycle %0d data %h",
                               k, w_err_code[k], r_cycle,
                               data_i[k*data_width_p +: data_width_p]);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bp_nonsynth_if_monitor.sv
// Bench for bp_nonsynth_if_monitor: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_bp_nonsynth_if_monitor;

    localparam int NC  = 4;
    localparam int DW  = 16;
    localparam int TO  = 4;
    localparam int CW  = 32;
    localparam int CWS = 3;
    localparam int SAT = 7;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en  = 1'b1;
    logic [NC-1:0]    v   = '0;
    logic [NC-1:0]    ready = '0;
    logic [NC*DW-1:0] data  = '0;

    logic             error_o;
    logic [1:0]       error_chan_o;
    logic [1:0]       error_code_o;
    logic [NC-1:0]    chan_error_o;
    logic [NC*CW-1:0] count_o;

    logic              s_error;
    logic [1:0]        s_chan;
    logic [1:0]        s_code;
    logic [NC-1:0]     s_chan_err;
    logic [NC*CWS-1:0] s_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: per channel a pending transfer (if any), its payload,
    // how many stalled cycles it has seen, whether the channel is dead, and
    // the number of completed transfers.
    bit          m_pend  [NC];
    logic [15:0] m_hold  [NC];
    int          m_stall [NC];
    bit          m_dead  [NC];
    int          m_cnt   [NC];
    bit          m_err;
    int          m_echan;
    int          m_ecode;

    always #5 clk = ~clk;

    bp_nonsynth_if_monitor #(
        .num_channels_p(NC), .data_width_p(DW), .timeout_cycles_p(TO),
        .count_width_p(CW), .fatal_on_error_p(0), .report_en_p(0)
    ) dut (
        .clk_i(clk), .reset_i(rst), .en_i(en), .v_i(v), .ready_i(ready), .data_i(data),
        .error_o(error_o), .error_chan_o(error_chan_o), .error_code_o(error_code_o),
        .chan_error_o(chan_error_o), .count_o(count_o)
    );

    bp_nonsynth_if_monitor #(
        .num_channels_p(NC), .data_width_p(DW), .timeout_cycles_p(TO),
        .count_width_p(CWS), .fatal_on_error_p(0), .report_en_p(0)
    ) dut_sat (
        .clk_i(clk), .reset_i(rst), .en_i(en), .v_i(v), .ready_i(ready), .data_i(data),
        .error_o(s_error), .error_chan_o(s_chan), .error_code_o(s_code),
        .chan_error_o(s_chan_err), .count_o(s_count)
    );

    function automatic int cnt_of(input int k);
        return int'(count_o[k*CW +: CW]);
    endfunction

    function automatic int scnt_of(input int k);
        return int'(s_count[k*CWS +: CWS]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            m_pend[k] = 0; m_hold[k] = '0; m_stall[k] = 0; m_dead[k] = 0; m_cnt[k] = 0;
        end
        m_err = 0; m_echan = 0; m_ecode = 0;
    endtask

    // Apply the protocol rules to the inputs about to be sampled
    task automatic model_step();
        int first;
        int fcode;
        int code;
        logic [15:0] d;
        first = -1;
        fcode = 0;
        if (!en) return;
        for (int k = 0; k < NC; k++) begin
            if (m_dead[k]) continue;
            d    = data[k*DW +: DW];
            code = 0;
            if (!m_pend[k]) begin
                if (v[k] && ready[k]) m_cnt[k]++;
                else if (v[k]) begin m_pend[k] = 1; m_hold[k] = d; m_stall[k] = 1; end
            end else begin
                if (!v[k])                  code = 1;
                else if (d != m_hold[k])    code = 2;
                else if (ready[k])          begin m_cnt[k]++; m_pend[k] = 0; end
                else if (m_stall[k] + 1 == TO) code = 3;
                else                        m_stall[k]++;
            end
            if (code != 0) begin
                m_dead[k] = 1;
                if (first < 0) begin first = k; fcode = code; end
            end
        end
        if (first >= 0 && !m_err) begin m_err = 1; m_echan = first; m_ecode = fcode; end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int k, input logic vv, input logic rr, input logic [15:0] dd);
        v[k] = vv; ready[k] = rr; data[k*DW +: DW] = dd;
    endtask

    task automatic apply_reset();
        en = 1'b1; v = '0; ready = '0; data = '0;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_checks++; if (error_o !== 1'b0) $display("FAIL reset_err: got %0b expected 0", error_o); else n_pass++;
        n_checks++; if (error_code_o !== 2'd0) $display("FAIL reset_code: got %0d expected 0", error_code_o); else n_pass++;
        n_checks++; if (chan_error_o !== 4'b0) $display("FAIL reset_chan_err: got %b expected 0000", chan_error_o); else n_pass++;
        n_checks++; if (count_o !== '0) $display("FAIL reset_count: got %h expected 0", count_o); else n_pass++;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        drv(0, 1, 1, 16'h1234);
        repeat (10) tick();
        drv(0, 0, 0, 16'h0);
        n_checks++; if (cnt_of(0) !== 10) $display("FAIL b2b_count: got %0d expected 10", cnt_of(0)); else n_pass++;
        n_checks++; if (scnt_of(0) !== SAT) $display("FAIL b2b_sat_count: got %0d expected %0d", scnt_of(0), SAT); else n_pass++;
        n_checks++; if (error_o !== 1'b0) $display("FAIL b2b_err: got %0b expected 0", error_o); else n_pass++;
        n_checks++; if (cnt_of(1) !== 0) $display("FAIL b2b_idle_count: got %0d expected 0", cnt_of(1)); else n_pass++;
    endtask

    task automatic test_valid_drop();
        apply_reset();
        drv(1, 1, 0, 16'hDEAD);
        repeat (3) tick();
        ready[1] = 1'b1;
        tick();
        n_checks++; if (cnt_of(1) !== 1) $display("FAIL vd_count: got %0d expected 1", cnt_of(1)); else n_pass++;
        n_checks++; if (error_o !== 1'b0) $display("FAIL vd_no_err: got %0b expected 0", error_o); else n_pass++;
        drv(1, 1, 0, 16'hBEEF);
        tick();
        v[1] = 1'b0;
        tick();
        n_checks++; if (error_o !== 1'b1) $display("FAIL vd_err: got %0b expected 1", error_o); else n_pass++;
        n_checks++; if (error_chan_o !== 2'd1) $display("FAIL vd_chan: got %0d expected 1", error_chan_o); else n_pass++;
        n_checks++; if (error_code_o !== 2'd1) $display("FAIL vd_code: got %0d expected 1", error_code_o); else n_pass++;
        n_checks++; if (chan_error_o !== 4'b0010) $display("FAIL vd_chan_err: got %b expected 0010", chan_error_o); else n_pass++;
    endtask

    task automatic test_data_change();
        apply_reset();
        drv(2, 1, 0, 16'h5);
        tick();
        drv(2, 1, 1, 16'h6);
        tick();
        drv(2, 0, 0, 16'h0);
        n_checks++; if (error_code_o !== 2'd2) $display("FAIL dc_code: got %0d expected 2", error_code_o); else n_pass++;
        n_checks++; if (error_chan_o !== 2'd2) $display("FAIL dc_chan: got %0d expected 2", error_chan_o); else n_pass++;
        n_checks++; if (cnt_of(2) !== 0) $display("FAIL dc_count: got %0d expected 0", cnt_of(2)); else n_pass++;
        // dead channel no longer counts
        drv(2, 1, 1, 16'h7);
        tick();
        n_checks++; if (cnt_of(2) !== 0) $display("FAIL dc_dead_count: got %0d expected 0", cnt_of(2)); else n_pass++;
    endtask

    task automatic test_timeout();
        apply_reset();
        drv(3, 1, 0, 16'hAA);
        repeat (3) tick();
        ready[3] = 1'b1;
        tick();
        n_checks++; if (error_o !== 1'b0) $display("FAIL to_three_err: got %0b expected 0", error_o); else n_pass++;
        n_checks++; if (cnt_of(3) !== 1) $display("FAIL to_three_count: got %0d expected 1", cnt_of(3)); else n_pass++;
        drv(3, 1, 0, 16'hBB);
        repeat (3) tick();
        n_checks++; if (error_o !== 1'b0) $display("FAIL to_early: got %0b expected 0", error_o); else n_pass++;
        tick();
        n_checks++; if (error_o !== 1'b1) $display("FAIL to_err: got %0b expected 1", error_o); else n_pass++;
        n_checks++; if (error_code_o !== 2'd3) $display("FAIL to_code: got %0d expected 3", error_code_o); else n_pass++;
        n_checks++; if (error_chan_o !== 2'd3) $display("FAIL to_chan: got %0d expected 3", error_chan_o); else n_pass++;
    endtask

    task automatic test_simultaneous();
        apply_reset();
        drv(1, 1, 0, 16'h11);
        drv(3, 1, 0, 16'h33);
        tick();
        drv(1, 0, 0, 16'h11);
        drv(3, 1, 0, 16'h34);
        tick();
        drv(3, 0, 0, 16'h0);
        n_checks++; if (error_chan_o !== 2'd1) $display("FAIL sim_chan: got %0d expected 1", error_chan_o); else n_pass++;
        n_checks++; if (error_code_o !== 2'd1) $display("FAIL sim_code: got %0d expected 1", error_code_o); else n_pass++;
        n_checks++; if (chan_error_o !== 4'b1010) $display("FAIL sim_chan_err: got %b expected 1010", chan_error_o); else n_pass++;
        drv(0, 1, 0, 16'h44);
        tick();
        drv(0, 1, 0, 16'h45);
        tick();
        n_checks++; if (chan_error_o !== 4'b1011) $display("FAIL sim_late_chan_err: got %b expected 1011", chan_error_o); else n_pass++;
        n_checks++; if (error_code_o !== 2'd1) $display("FAIL sim_late_code: got %0d expected 1", error_code_o); else n_pass++;
        n_checks++; if (error_chan_o !== 2'd1) $display("FAIL sim_late_chan: got %0d expected 1", error_chan_o); else n_pass++;
    endtask

    task automatic test_enable_freeze();
        apply_reset();
        drv(3, 1, 0, 16'h33);
        repeat (2) tick();
        en = 1'b0;
        drv(3, 0, 0, 16'h44);
        drv(0, 1, 1, 16'h01);
        repeat (5) tick();
        n_checks++; if (error_o !== 1'b0) $display("FAIL en_frozen_err: got %0b expected 0", error_o); else n_pass++;
        n_checks++; if (cnt_of(0) !== 0) $display("FAIL en_frozen_count: got %0d expected 0", cnt_of(0)); else n_pass++;
        en = 1'b1;
        drv(3, 1, 0, 16'h33);
        drv(0, 0, 0, 16'h0);
        tick();
        n_checks++; if (error_o !== 1'b0) $display("FAIL en_resume_early: got %0b expected 0", error_o); else n_pass++;
        tick();
        n_checks++; if (error_code_o !== 2'd3) $display("FAIL en_resume_timeout: got %0d expected 3", error_code_o); else n_pass++;
    endtask

    task automatic test_saturation();
        apply_reset();
        drv(2, 1, 1, 16'h9);
        repeat (9) tick();
        drv(2, 0, 0, 16'h0);
        n_checks++; if (scnt_of(2) !== SAT) $display("FAIL sat_count: got %0d expected %0d", scnt_of(2), SAT); else n_pass++;
        n_checks++; if (cnt_of(2) !== 9) $display("FAIL sat_wide_count: got %0d expected 9", cnt_of(2)); else n_pass++;
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        drv(0, 1, 1, 16'h70);
        repeat (7) tick();
        n_checks++; if (cnt_of(0) !== 7) $display("FAIL rms_pre_count: got %0d expected 7", cnt_of(0)); else n_pass++;
        ready[0] = 1'b0;
        repeat (2) tick();
        #3 rst = 1'b1;
        #1;
        n_checks++; if (cnt_of(0) !== 0) $display("FAIL rms_count: got %0d expected 0", cnt_of(0)); else n_pass++;
        n_checks++; if (scnt_of(0) !== 0) $display("FAIL rms_sat_count: got %0d expected 0", scnt_of(0)); else n_pass++;
        n_checks++; if (error_o !== 1'b0) $display("FAIL rms_err: got %0b expected 0", error_o); else n_pass++;
        n_checks++; if (chan_error_o !== 4'b0) $display("FAIL rms_chan_err: got %b expected 0000", chan_error_o); else n_pass++;
        model_reset();
        drv(0, 0, 0, 16'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        n_checks++; if (error_o !== 1'b0) $display("FAIL rms_post_err: got %0b expected 0", error_o); else n_pass++;
    endtask

    task automatic test_random();
        for (int ep = 0; ep < 6; ep++) begin
            apply_reset();
            for (int c = 0; c < 150; c++) begin
                en = ($urandom % 10) != 0;
                for (int k = 0; k < NC; k++) begin
                    v[k]     = ($urandom % 6) != 0;
                    ready[k] = ($urandom % 3) == 0;
                    if (($urandom % 12) == 0) data[k*DW +: DW] = 16'($urandom % 4);
                end
                tick();
                n_checks++; if (error_o !== m_err) $display("FAIL rnd_err ep%0d c%0d: got %0b expected %0b", ep, c, error_o, m_err); else n_pass++;
                n_checks++; if (error_chan_o !== 2'(m_echan)) $display("FAIL rnd_chan ep%0d c%0d: got %0d expected %0d", ep, c, error_chan_o, m_echan); else n_pass++;
                n_checks++; if (error_code_o !== 2'(m_ecode)) $display("FAIL rnd_code ep%0d c%0d: got %0d expected %0d", ep, c, error_code_o, m_ecode); else n_pass++;
                for (int k = 0; k < NC; k++) begin
                    n_checks++; if (chan_error_o[k] !== m_dead[k]) $display("FAIL rnd_chan_err%0d ep%0d c%0d: got %0b expected %0b", k, ep, c, chan_error_o[k], m_dead[k]); else n_pass++;
                    n_checks++; if (cnt_of(k) !== m_cnt[k]) $display("FAIL rnd_count%0d ep%0d c%0d: got %0d expected %0d", k, ep, c, cnt_of(k), m_cnt[k]); else n_pass++;
                    n_checks++; if (scnt_of(k) !== ((m_cnt[k] > SAT) ? SAT : m_cnt[k])) $display("FAIL rnd_sat_count%0d ep%0d c%0d: got %0d expected %0d", k, ep, c, scnt_of(k), (m_cnt[k] > SAT) ? SAT : m_cnt[k]); else n_pass++;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_back_to_back();
        test_valid_drop();
        test_data_change();
        test_timeout();
        test_simultaneous();
        test_enable_freeze();
        test_saturation();
        test_reset_mid_stall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
